// File: rtl/md5_round_inv.sv
// md5_round_inv: iterative inverse of the rotate-left-7 MD5 round step.
// Recovers the pre-round state from a post-round state and the (m,k) schedule fed in reverse.
module md5_round_inv #(
  parameter int STEPS = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  // All three channels transfer on a rising edge where valid and ready are both high;
  // ready never depends on valid, and valid holds its payload until the transfer.
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [W-1:0] c_in,
  input  logic [W-1:0] d_in,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [W-1:0] m,
  input  logic [W-1:0] k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic [W-1:0] c_out,
  output logic [W-1:0] d_out,
  output logic         busy
);
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, b_q, c_q, d_q;
  logic [W-1:0]  a_d, b_d, c_d, d_d;

  // One inverse step: undo the word shift, then peel the rotation and the additions off B.
  logic [W-1:0] inv_a, inv_b, inv_c, inv_d, rot, sum, f;
  assign inv_b = c_q;
  assign inv_c = d_q;
  assign inv_d = a_q;
  assign rot   = b_q - inv_b;
  assign sum   = {rot[6:0], rot[W-1:7]};
  assign f     = (inv_b & inv_c) | (~inv_b & inv_d);
  assign inv_a = sum - f - m - k;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (w_valid && (cnt_q == LAST)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    w_ready   = (state_q == RUN);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
  end

  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    d_d   = d_q;
    if ((state_q == IDLE) && in_valid) begin
      cnt_d = '0;
      a_d   = a_in;
      b_d   = b_in;
      c_d   = c_in;
      d_d   = d_in;
    end else if ((state_q == RUN) && w_valid) begin
      cnt_d = cnt_q + CW'(1);
      a_d   = inv_a;
      b_d   = inv_b;
      c_d   = inv_c;
      d_d   = inv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      d_q   <= d_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign c_out = c_q;
  assign d_out = d_q;
endmodule
